// File: rtl/apb_mst_pkg.sv
// Constants and helpers for the APB requester; bus types live in types_amba_pkg.
package apb_mst_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned StrbW = 4;

    localparam logic [2:0] ProtNone = 3'b000;

    // Counter width able to hold max_cnt; at least one bit so a disabled timeout still elaborates.
    function automatic int unsigned cnt_width(input int unsigned max_cnt);
        return (max_cnt > 0) ? $clog2(max_cnt + 1) : 1;
    endfunction

endpackage

// File: rtl/types_amba_pkg.sv
// AMBA APB bus structs shared between requesters and completers.
// apb_in_type is what a completer receives; apb_out_type is what it returns.
package types_amba_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        pselx;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_in_type;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } apb_out_type;

endpackage

// File: rtl/apb_mst_if.sv
// APB bus bundle: requester drives apbo, completer answers on apbi.
interface apb_mst_if;
    import types_amba_pkg::*;

    apb_in_type  apbo;
    apb_out_type apbi;

    modport master (output apbo, input apbi);
    modport slave  (input apbo, output apbi);

endinterface

// File: rtl/apb_mst.sv
// Single-outstanding APB requester: request/response handshake in, APB transfer out.
// Every output is a register; an optional ACCESS-phase timeout ends stuck transfers with an error.
module apb_mst
    import apb_mst_pkg::*;
    import types_amba_pkg::*;
#(
    parameter int unsigned timeout = 255
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [AddrW-1:0]  i_req_addr,
    input  logic              i_req_write,
    input  logic [DataW-1:0]  i_req_wdata,
    input  logic [StrbW-1:0]  i_req_wstrb,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DataW-1:0]  o_resp_rdata,
    output logic              o_resp_err,
    output apb_in_type        o_apbo,
    input  apb_out_type       i_apbi
);

    localparam int unsigned CntW = cnt_width(timeout);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    typedef struct packed {
        logic             req_ready;
        logic             resp_valid;
        logic [DataW-1:0] resp_rdata;
        logic             resp_err;
        apb_in_type       apbo;
        logic [CntW-1:0]  cnt;
    } regs_t;

    state_e          state_q, state_d;
    regs_t           r_q, r_d;
    logic [CntW-1:0] cnt_inc;
    logic            timed_out;

    assign cnt_inc   = r_q.cnt + 1'b1;
    assign timed_out = (timeout != 0) && (cnt_inc == CntW'(timeout));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_q           <= '0;
            r_q.req_ready <= 1'b1;
        end else begin
            r_q <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (i_req_valid && r_q.req_ready) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (i_apbi.pready || timed_out) state_d = StResp;
            StResp:   if (i_resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        r_d            = r_q;
        r_d.apbo.pprot = ProtNone;
        unique case (state_q)
            StIdle: begin
                if (i_req_valid && r_q.req_ready) begin
                    r_d.req_ready    = 1'b0;
                    r_d.apbo.paddr   = i_req_addr;
                    r_d.apbo.pwrite  = i_req_write;
                    r_d.apbo.pwdata  = i_req_write ? i_req_wdata : '0;
                    r_d.apbo.pstrb   = i_req_write ? i_req_wstrb : '0;
                    r_d.apbo.pselx   = 1'b1;
                    r_d.apbo.penable = 1'b0;
                end
            end
            StSetup: begin
                r_d.apbo.penable = 1'b1;
                r_d.cnt          = '0;
            end
            StAccess: begin
                // pready is tested first so it wins over a timeout in the same cycle.
                if (i_apbi.pready) begin
                    r_d.apbo.pselx   = 1'b0;
                    r_d.apbo.penable = 1'b0;
                    r_d.resp_valid   = 1'b1;
                    r_d.resp_rdata   = r_q.apbo.pwrite ? '0 : i_apbi.prdata;
                    r_d.resp_err     = i_apbi.pslverr;
                end else if (timed_out) begin
                    r_d.apbo.pselx   = 1'b0;
                    r_d.apbo.penable = 1'b0;
                    r_d.resp_valid   = 1'b1;
                    r_d.resp_rdata   = '0;
                    r_d.resp_err     = 1'b1;
                end else begin
                    r_d.cnt = cnt_inc;
                end
            end
            StResp: begin
                if (i_resp_ready) begin
                    r_d.resp_valid = 1'b0;
                    r_d.req_ready  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_req_ready  = r_q.req_ready;
    assign o_resp_valid = r_q.resp_valid;
    assign o_resp_rdata = r_q.resp_rdata;
    assign o_resp_err   = r_q.resp_err;
    assign o_apbo       = r_q.apbo;

endmodule

// File: tb/tb_apb_mst.sv
// Randomized bench for apb_mst: a transfer-level model predicts APB phases, latency and response.
module tb_apb_mst;
    import types_amba_pkg::*;

    localparam int unsigned TbTimeout = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    apb_mst_if bus ();

    apb_mst #(.timeout(TbTimeout)) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_write  (req_write),
        .i_req_wdata  (req_wdata),
        .i_req_wstrb  (req_wstrb),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_apbo       (bus.apbo),
        .i_apbi       (bus.apbi)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic completer_noise();
        bus.apbi.pready  = 1'($urandom);
        bus.apbi.pslverr = 1'($urandom);
        bus.apbi.prdata  = $urandom;
    endtask

    // Garbage on the request side; the block must ignore it outside IDLE.
    task automatic req_noise();
        req_valid = 1'($urandom);
        req_addr  = $urandom;
        req_write = 1'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    task automatic check_bus(input string tag, input logic sel, input logic en,
                             input logic [31:0] addr, input logic wr,
                             input logic [31:0] wd, input logic [3:0] st);
        check_eq({tag, ".pselx"}, 32'(bus.apbo.pselx), 32'(sel));
        check_eq({tag, ".penable"}, 32'(bus.apbo.penable), 32'(en));
        check_eq({tag, ".paddr"}, bus.apbo.paddr, addr);
        check_eq({tag, ".pwrite"}, 32'(bus.apbo.pwrite), 32'(wr));
        check_eq({tag, ".pwdata"}, bus.apbo.pwdata, wd);
        check_eq({tag, ".pstrb"}, 32'(bus.apbo.pstrb), 32'(st));
        check_eq({tag, ".pprot"}, 32'(bus.apbo.pprot), 32'(0));
    endtask

    // wt: ACCESS cycles the completer holds pready low before raising it.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int unsigned wt, input logic [31:0] rd,
                           input logic serr, input int unsigned hold);
        bit          to;
        int unsigned n_acc;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        to      = (wt >= TbTimeout);
        n_acc   = to ? TbTimeout : wt + 1;
        exp_rd  = (to || wr) ? 32'h0 : rd;
        exp_err = to ? 1'b1 : serr;
        exp_wd  = wr ? wd : 32'h0;
        exp_st  = wr ? st : 4'h0;

        @(negedge clk);
        check_eq("idle.req_ready", 32'(req_ready), 32'(1));
        check_eq("idle.resp_valid", 32'(resp_valid), 32'(0));
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        req_wstrb = st;
        resp_ready = 1'($urandom);
        completer_noise();

        @(negedge clk);
        check_bus("setup", 1'b1, 1'b0, addr, wr, exp_wd, exp_st);
        check_eq("setup.req_ready", 32'(req_ready), 32'(0));
        check_eq("setup.resp_valid", 32'(resp_valid), 32'(0));
        req_noise();
        resp_ready = 1'($urandom);
        completer_noise();

        for (int k = 1; k <= int'(n_acc); k++) begin
            @(negedge clk);
            check_bus("access", 1'b1, 1'b1, addr, wr, exp_wd, exp_st);
            check_eq("access.resp_valid", 32'(resp_valid), 32'(0));
            req_noise();
            resp_ready = 1'($urandom);
            if (!to && k == int'(wt) + 1) begin
                bus.apbi.pready  = 1'b1;
                bus.apbi.prdata  = rd;
                bus.apbi.pslverr = serr;
            end else begin
                bus.apbi.pready  = 1'b0;
                bus.apbi.prdata  = $urandom;
                bus.apbi.pslverr = 1'($urandom);
            end
        end

        for (int i = 0; i <= int'(hold); i++) begin
            @(negedge clk);
            check_eq("resp.valid", 32'(resp_valid), 32'(1));
            check_eq("resp.rdata", resp_rdata, exp_rd);
            check_eq("resp.err", 32'(resp_err), 32'(exp_err));
            check_eq("resp.req_ready", 32'(req_ready), 32'(0));
            check_eq("resp.pselx", 32'(bus.apbo.pselx), 32'(0));
            check_eq("resp.penable", 32'(bus.apbo.penable), 32'(0));
            req_noise();
            completer_noise();
            resp_ready = (i == int'(hold));
        end

        @(negedge clk);
        check_eq("done.resp_valid", 32'(resp_valid), 32'(0));
        check_eq("done.req_ready", 32'(req_ready), 32'(1));
        check_eq("done.pselx", 32'(bus.apbo.pselx), 32'(0));
        req_valid  = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic reset_in_access();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        req_write = 1'b0;
        bus.apbi.pready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rst.pre.penable", 32'(bus.apbo.penable), 32'(1));
        #2 nrst = 1'b0;
        #1;
        check_eq("rst.async.pselx", 32'(bus.apbo.pselx), 32'(0));
        check_eq("rst.async.penable", 32'(bus.apbo.penable), 32'(0));
        check_eq("rst.async.resp_valid", 32'(resp_valid), 32'(0));
        bus.apbi.pready = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst.after.req_ready", 32'(req_ready), 32'(1));
            check_eq("rst.after.resp_valid", 32'(resp_valid), 32'(0));
            check_eq("rst.after.pselx", 32'(bus.apbo.pselx), 32'(0));
        end
        bus.apbi.pready = 1'b0;
    endtask

    initial begin
        bus.apbi = '0;
        repeat (2) @(negedge clk);
        check_eq("reset.req_ready", 32'(req_ready), 32'(1));
        check_eq("reset.resp_valid", 32'(resp_valid), 32'(0));
        check_eq("reset.rdata", resp_rdata, 32'h0);
        check_eq("reset.err", 32'(resp_err), 32'(0));
        check_bus("reset", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        nrst = 1'b1;

        // Zero-wait read, minimum latency.
        do_xfer(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, 0);
        // Write with three wait states.
        do_xfer(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 3, 32'hCAFE_F00D, 1'b0, 0);
        // Slave error on a read.
        do_xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1, 32'hA5A5_5A5A, 1'b1, 1);
        // Completer never ready, then a normal transfer.
        do_xfer(1'b0, 32'h0000_0030, 32'h0, 4'h0, 1000, 32'h1111_2222, 1'b0, 0);
        do_xfer(1'b0, 32'h0000_0034, 32'h0, 4'h0, 0, 32'h3333_4444, 1'b0, 0);
        // pready arriving in the very cycle the counter would expire.
        do_xfer(1'b1, 32'h0000_0038, 32'hFFFF_0000, 4'h3, TbTimeout - 1, 32'h0, 1'b1, 0);
        // Consumer stalls the response for five cycles.
        do_xfer(1'b0, 32'h0000_003C, 32'h0, 4'h0, 2, 32'h7777_8888, 1'b0, 5);

        reset_in_access();

        for (int n = 0; n < 40; n++) begin
            do_xfer(1'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, TbTimeout + 2), $urandom, 1'($urandom),
                    $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_mst.md
APB_MST -- requirements
Module: apb_mst

Interface
REQ-001 Parameter timeout, default 255, means the maximum ACCESS-phase cycles to wait for pready; 0 disables the timeout.
REQ-002 Port i_clk  in  1  is the single system clock; all state updates on its rising edge.
REQ-003 Port i_nrst  in  1  is the reset: asynchronous, active-low.
REQ-004 Port i_req_valid  in  1  signals that a request is present.
REQ-005 Port o_req_ready  out  1  signals that the block accepts a request this cycle.
REQ-006 Port i_req_addr  in  32  is the request byte address.
REQ-007 Port i_req_write  in  1  selects the direction: 1=write, 0=read.
REQ-008 Port i_req_wdata  in  32  is the write data.
REQ-009 Port i_req_wstrb  in  4  is the write byte strobes.
REQ-010 Port o_resp_valid  out  1  signals that a response is present.
REQ-011 Port i_resp_ready  in  1  signals that the consumer takes the response.
REQ-012 Port o_resp_rdata  out  32  is the read data.
REQ-013 Port o_resp_err  out  1  is set for a slave error or a timeout.
REQ-014 Port o_apbo  out  types_amba_pkg::apb_in_type  is the APB requester bus (paddr, pprot, pselx, penable, pwrite, pwdata, pstrb).
REQ-015 Port i_apbi  in  types_amba_pkg::apb_out_type  is the APB completer response (prdata, pready, pslverr).

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP; all outputs come from registers.
REQ-017 o_req_ready SHALL be 1 only in IDLE; i_req_valid&o_req_ready latches addr/write/wdata/wstrb and goes to SETUP.
REQ-018 SETUP SHALL drive pselx=1, penable=0 and the latched fields, then go to ACCESS unconditionally.
REQ-019 ACCESS SHALL drive pselx=1, penable=1 and hold all fields stable until pready=1 or a timeout occurs.
REQ-020 On pready=1 in ACCESS: pselx=0 and penable=0 next cycle; resp_rdata=prdata for a read, 0 for a write; resp_err=pslverr; go to RESP.
REQ-021 Timeout: the counter clears on ACCESS entry and increments each ACCESS cycle with pready=0; when it equals timeout (timeout>0), end as REQ-020 with resp_rdata=0 and resp_err=1.
REQ-022 When pready and the timeout condition occur in the same cycle, pready SHALL win.
REQ-023 RESP SHALL hold o_resp_valid=1 and stable data until i_resp_ready=1, then go to IDLE; no new request is accepted in that cycle.
REQ-024 Minimum latency: request accepted at cycle T, SETUP at T+1, ACCESS at T+2, pready at T+2 gives o_resp_valid at T+3; throughput is one transfer per 4 cycles.
REQ-025 pprot SHALL be constant 3'b000; paddr SHALL be driven as i_req_addr unmodified.
REQ-026 pwdata and pstrb SHALL be driven 0 on reads.
REQ-027 Inputs outside IDLE SHALL be ignored; i_resp_ready outside RESP SHALL be ignored.

Reset
REQ-028 Asserting i_nrst=0 at any time, including mid-transfer, SHALL force IDLE immediately, with an in-flight transfer aborted and no response issued.
REQ-029 Reset values SHALL be: o_req_ready=1 once in IDLE (register reset 1), o_resp_valid=0, o_resp_rdata=0, o_resp_err=0, all o_apbo fields 0, counter 0.

Structure
REQ-030 APB types SHALL come from types_amba_pkg; no new shared typedefs.
REQ-031 The state encoding and the registers struct SHALL be local to the module.
REQ-032 The block SHALL have no sub-module; the timeout counter is inline.

Verification
REQ-033 Read, zero-wait completer returning prdata=32'hDEADBEEF: request at T gives pselx at T+1, penable at T+2, resp_valid at T+3 with rdata=32'hDEADBEEF and err=0.
REQ-034 Write addr=32'h0000_0010, wdata=32'h1234_5678, wstrb=4'hF, completer waits 3 cycles: paddr, pwdata and pstrb stable over all ACCESS cycles; response err=0 and rdata=0.
REQ-035 Completer returns pslverr=1 on a read: resp_err=1 and rdata=prdata.
REQ-036 timeout=4 with a completer that never asserts pready: after 4 ACCESS cycles pselx=0, then resp_valid=1, err=1, rdata=0; the next request proceeds normally.
REQ-037 i_resp_ready held 0 for 5 cycles: resp_valid and data stay stable and o_req_ready=0; ready=1 returns the block to IDLE the next cycle.
REQ-038 i_nrst pulsed low during ACCESS: pselx and penable drop asynchronously, no resp_valid appears, and o_req_ready=1 after reset release.
